gin_bus_buffered: RTL and testbench

Next-generation global-interconnect bus for one PE-array row. It accepts tagged packets from the row master into an ingress FIFO and multicasts each packet to every column slave whose scan-configured ID equals the packet tag. A packet retires only after all targeted slaves have accepted it, so slaves may accept on different cycles. The block also drops packets that match no slave and counts them, and keeps the serial ID scan chain used by the existing bus for configuration.

---
 rtl/gin_bus_buffered.sv | 224 ++++++++++++++++++++++
 tb/tb_gin_bus_buffered.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gin_bus_buffered.sv
// -----------------------------------------------------------------------------
// gin_bus_buffered
//
// Global-interconnect bus for one PE-array row. Packets from the row master
// are queued in a small ingress FIFO. The head packet is multicast to every
// column slave whose scan-programmed ID matches the packet tag. The head only
// retires once every targeted slave has taken it, so slaves may accept on
// different cycles. Packets that match no slave are dropped and counted.
//
// Optional build macro:
//   GIN_BROADCAST_EN  - when defined, an all-ones tag targets every slave and
//                       never counts as a miss. When undefined, all-ones is an
//                       ordinary tag compared against the slave IDs.
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous reset, active low
//   tag           in   destination tag of the master packet
//   master_valid  in   master packet valid
//   master_data   in   master payload
//   master_ready  out  ingress FIFO can take a packet (not full)
//   slave_ready   in   per-slave ready
//   slave_valid   out  per-slave valid
//   slave_data    out  head-of-FIFO payload, shared by all slaves
//   set_id        in   scan-chain shift enable; freezes delivery while high
//   ID_scan_in    in   scan input, enters slot 0
//   ID_scan_out   out  scan output, slot NUMS_SLAVE-1
//   busy          out  FIFO not empty
//   miss_count    out  saturating count of dropped (unmatched) packets
// -----------------------------------------------------------------------------

`ifndef NUMS_PE_COL
`define NUMS_PE_COL 4
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef DATA_BITS
`define DATA_BITS 8
`endif

module gin_bus_buffered #(
    parameter int NUMS_SLAVE = `NUMS_PE_COL,
    parameter int ID_SIZE    = `XID_BITS,
    parameter int DATA_SIZE  = `DATA_BITS,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_SIZE-1:0]    tag,
    input  logic                  master_valid,
    input  logic [DATA_SIZE-1:0]  master_data,
    output logic                  master_ready,
    input  logic [NUMS_SLAVE-1:0] slave_ready,
    output logic [NUMS_SLAVE-1:0] slave_valid,
    output logic [DATA_SIZE-1:0]  slave_data,
    input  logic                  set_id,
    input  logic [ID_SIZE-1:0]    ID_scan_in,
    output logic [ID_SIZE-1:0]    ID_scan_out,
    output logic                  busy,
    output logic [CNT_BITS-1:0]   miss_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = ID_SIZE + DATA_SIZE;

    localparam logic [PTR_W:0]    PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    // ---------------------------------------------------------------------
    // Slave ID scan chain
    // ---------------------------------------------------------------------
    logic [ID_SIZE-1:0] id_q [NUMS_SLAVE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUMS_SLAVE; i++) begin
                id_q[i] <= '0;
            end
        end else if (set_id) begin
            id_q[0] <= ID_scan_in;
            for (int i = 1; i < NUMS_SLAVE; i++) begin
                id_q[i] <= id_q[i-1];
            end
        end
    end

    assign ID_scan_out = id_q[NUMS_SLAVE-1];

    // ---------------------------------------------------------------------
    // Ingress FIFO; pointers carry one extra wrap bit so full and empty are
    // distinguishable when the index bits are equal.
    // ---------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [ID_SIZE-1:0] head_tag;
    logic [DATA_SIZE-1:0] head_data;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Ready depends on registered occupancy only: a pop in the same cycle
    // does not open a slot for a push while full.
    assign master_ready = !full;
    assign push         = master_valid && !full;
    assign busy         = !empty;

    assign head_entry = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign head_tag   = head_entry[ENTRY_W-1:DATA_SIZE];
    assign head_data  = head_entry[DATA_SIZE-1:0];

    // Storage is cleared on reset so slave_data reads zero until the first
    // packet arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else if (push) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= {tag, master_data};
        end
    end

    assign wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    assign rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ---------------------------------------------------------------------
    // Target mask, recomputed every cycle against the live IDs so that a
    // reprogrammed chain takes effect as soon as set_id drops.
    // ---------------------------------------------------------------------
    logic [NUMS_SLAVE-1:0] target;

    always_comb begin
        target = '0;
        for (int i = 0; i < NUMS_SLAVE; i++) begin
            target[i] = (id_q[i] == head_tag);
        end
`ifdef GIN_BROADCAST_EN
        if (head_tag == {ID_SIZE{1'b1}}) begin
            target = '1;
        end
`endif
    end

    // ---------------------------------------------------------------------
    // Delivery and retire
    // ---------------------------------------------------------------------
    logic [NUMS_SLAVE-1:0] done_q, done_d;
    logic [NUMS_SLAVE-1:0] acc;
    logic [NUMS_SLAVE-1:0] served;
    logic                  deliver_en;
    logic                  retire;
    logic                  miss;

    assign deliver_en  = !empty && !set_id;
    assign slave_valid = {NUMS_SLAVE{deliver_en}} & target & ~done_q;
    assign slave_data  = head_data;
    assign acc         = slave_valid & slave_ready;

    // Done bits left over from a previous target mask are masked out here,
    // so they neither block nor fake a retire.
    assign served = (done_q | acc) & target;
    assign retire = deliver_en && (target != '0) && (served == target);
    assign miss   = deliver_en && (target == '0);
    assign pop    = retire || miss;

    always_comb begin
        done_d = done_q;
        if (pop) begin
            done_d = '0;
        end else if (!set_id) begin
            done_d = done_q | acc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= '0;
        end else begin
            done_q <= done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Miss counter, saturating
    // ---------------------------------------------------------------------
    logic [CNT_BITS-1:0] miss_count_q, miss_count_d;

    always_comb begin
        miss_count_d = miss_count_q;
        if (miss && (miss_count_q != {CNT_BITS{1'b1}})) begin
            miss_count_d = miss_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss_count_q <= '0;
        end else begin
            miss_count_q <= miss_count_d;
        end
    end

    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_gin_bus_buffered.sv
module tb_gin_bus_buffered;

    localparam int N   = 4;
    localparam int IDW = 4;
    localparam int DW  = 8;
    localparam int CW  = 8;

`ifdef GIN_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [IDW-1:0] tag = '0;
    logic           master_valid = 1'b0;
    logic [DW-1:0]  master_data = '0;
    logic           master_ready;
    logic [N-1:0]   slave_ready = '0;
    logic [N-1:0]   slave_valid;
    logic [DW-1:0]  slave_data;
    logic           set_id = 1'b0;
    logic [IDW-1:0] ID_scan_in = '0;
    logic [IDW-1:0] ID_scan_out;
    logic           busy;
    logic [CW-1:0]  miss_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    gin_bus_buffered #(
        .NUMS_SLAVE(N), .ID_SIZE(IDW), .DATA_SIZE(DW), .FIFO_DEPTH(4), .CNT_BITS(CW)
    ) dut (
        .clk(clk), .rst(rst), .tag(tag), .master_valid(master_valid),
        .master_data(master_data), .master_ready(master_ready),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .slave_data(slave_data),
        .set_id(set_id), .ID_scan_in(ID_scan_in), .ID_scan_out(ID_scan_out),
        .busy(busy), .miss_count(miss_count)
    );

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic scan4(input int a, input int b, input int c, input int d);
        int v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int k = 0; k < 4; k++) begin
            set_id = 1'b1;
            ID_scan_in = v[k][IDW-1:0];
            tick();
        end
        set_id = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vals[8];
        int nv[4];

        // reset state
        #12;
        check_eq("rst_ready", master_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_valid", slave_valid, 0);
        check_eq("rst_miss", miss_count, 0);
        check_eq("rst_data", slave_data, 0);
        check_eq("rst_scan", ID_scan_out, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // scan chain: 3,2,1,0 twice leaves id[i]=i
        vals = '{3, 2, 1, 0, 3, 2, 1, 0};
        for (int k = 0; k < 8; k++) begin
            set_id = 1'b1;
            ID_scan_in = vals[k][IDW-1:0];
            tick();
            if (k >= 3) check_eq("scan_out", ID_scan_out, vals[k-3]);
        end
        set_id = 1'b0;

        // tag 2 goes to slave 2 only, retires next edge
        tag = 4'd2; master_data = 8'h3C; master_valid = 1'b1; slave_ready = 4'hF;
        tick();
        master_valid = 1'b0;
        #1;
        check_eq("t2_valid", slave_valid, 4'b0100);
        check_eq("t2_data", slave_data, 8'h3C);
        check_eq("t2_busy", busy, 1);
        tick();
        check_eq("t2_busy_after", busy, 0);
        check_eq("t2_valid_after", slave_valid, 0);
        slave_ready = '0;

        // ids [6,5,7,5]: slaves 1 and 3 share ID 5, accept on different cycles
        scan4(5, 7, 5, 6);
        tag = 4'd5; master_data = 8'hA5; master_valid = 1'b1;
        tick();
        master_valid = 1'b0;
        #1;
        check_eq("mc_c0_valid", slave_valid, 4'b1010);
        tick();
        slave_ready = 4'b0010;
        #1;
        check_eq("mc_c1_valid", slave_valid, 4'b1010);
        check_eq("mc_c1_data", slave_data, 8'hA5);
        tick();
        slave_ready = 4'b0000;
        #1;
        check_eq("mc_c2_valid", slave_valid, 4'b1000);
        check_eq("mc_c2_data", slave_data, 8'hA5);
        tick();
        check_eq("mc_c3_valid", slave_valid, 4'b1000);
        check_eq("mc_c3_busy", busy, 1);
        tick();
        slave_ready = 4'b1000;
        #1;
        check_eq("mc_c4_valid", slave_valid, 4'b1000);
        check_eq("mc_c4_data", slave_data, 8'hA5);
        tick();
        check_eq("mc_pop_busy", busy, 0);
        check_eq("mc_pop_valid", slave_valid, 0);
        slave_ready = '0;

        // fill the FIFO, hold the 5th, release by retiring the head
        tag = 4'd5;
        for (int p = 1; p <= 4; p++) begin
            master_data = p[DW-1:0];
            master_valid = 1'b1;
            tick();
        end
        master_data = 8'd5;
        #1;
        check_eq("full_ready", master_ready, 0);
        tick();
        slave_ready = 4'b1010;
        #1;
        check_eq("full_ready_hold", master_ready, 0);
        check_eq("full_head_valid", slave_valid, 4'b1010);
        check_eq("full_head_data", slave_data, 1);
        tick();
        check_eq("after_retire_ready", master_ready, 1);
        check_eq("after_retire_data", slave_data, 2);
        tick();
        master_valid = 1'b0;
        #1;
        check_eq("drain_data3", slave_data, 3);
        check_eq("drain_ready", master_ready, 1);
        tick();
        check_eq("drain_data4", slave_data, 4);
        tick();
        check_eq("drain_data5", slave_data, 5);
        tick();
        check_eq("drain_empty", busy, 0);
        slave_ready = '0;

        // three packets to an unused tag are dropped and counted
        tag = 4'd9; master_data = 8'h11; master_valid = 1'b1;
        tick();
        check_eq("miss_valid0", slave_valid, 0);
        check_eq("miss_cnt0", miss_count, 0);
        tick();
        check_eq("miss_valid1", slave_valid, 0);
        check_eq("miss_cnt1", miss_count, 1);
        tick();
        master_valid = 1'b0;
        #1;
        check_eq("miss_cnt2", miss_count, 2);
        check_eq("miss_busy2", busy, 1);
        tick();
        check_eq("miss_cnt3", miss_count, 3);
        check_eq("miss_busy3", busy, 0);

        // set_id mid-delivery: ids [1,2,0,2] then reprogram to [2,2,2,9]
        scan4(2, 0, 2, 1);
        tag = 4'd2; master_data = 8'h5A; master_valid = 1'b1;
        tick();
        master_valid = 1'b0;
        slave_ready = 4'b0010;
        #1;
        check_eq("sid_valid0", slave_valid, 4'b1010);
        tick();
        slave_ready = '0;
        #1;
        check_eq("sid_valid1", slave_valid, 4'b1000);
        nv = '{9, 2, 2, 2};
        for (int k = 0; k < 4; k++) begin
            set_id = 1'b1;
            ID_scan_in = nv[k][IDW-1:0];
            #1;
            check_eq("sid_frozen_valid", slave_valid, 0);
            check_eq("sid_frozen_busy", busy, 1);
            tick();
        end
        set_id = 1'b0;
        #1;
        check_eq("sid_resume_valid", slave_valid, 4'b0101);
        check_eq("sid_resume_data", slave_data, 8'h5A);
        check_eq("sid_miss_same", miss_count, 3);
        slave_ready = 4'b0101;
        tick();
        check_eq("sid_retired", busy, 0);
        check_eq("sid_valid_after", slave_valid, 0);
        slave_ready = '0;

        // all-ones tag, no slave has ID 15
        tag = 4'hF; master_data = 8'hEE; master_valid = 1'b1; slave_ready = 4'hF;
        tick();
        master_valid = 1'b0;
        #1;
        check_eq("ones_valid", slave_valid, BCAST ? 4'hF : 4'h0);
        tick();
        check_eq("ones_miss", miss_count, BCAST ? 3 : 4);
        check_eq("ones_busy", busy, 0);
        slave_ready = '0;

        // reset mid-packet discards everything
        tag = 4'd2; master_data = 8'h77; master_valid = 1'b1;
        tick();
        master_valid = 1'b0;
        #1;
        check_eq("mid_valid", slave_valid, 4'b0111);
        rst = 1'b0;
        #1;
        check_eq("mid_rst_valid", slave_valid, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", master_ready, 1);
        check_eq("mid_rst_miss", miss_count, 0);
        check_eq("mid_rst_data", slave_data, 0);
        check_eq("mid_rst_scan", ID_scan_out, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // miss counter saturation
        tag = 4'd9; master_valid = 1'b1;
        repeat (300) tick();
        master_valid = 1'b0;
        tick();
        tick();
        check_eq("sat_miss", miss_count, 255);
        check_eq("sat_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
